scalar_dcache: RTL

- Direct-mapped, write-through, write-update, no-write-allocate data cache.
- Sits directly downstream of the scalar load/store unit and serves its dcache-side requests: dmemaddr, dmemREN, dmemWEN, dmemstore in; dhit_in, dmem_in out.
- On a miss or a write, the cache drives a single-word memory port with a wait handshake.
- One word per line; the cache holds no dirty state.

---
 rtl/scalar_dcache.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/scalar_dcache.sv
// scalar_dcache: direct-mapped, write-through, write-update,
// no-write-allocate data cache. Optional macro: SCALAR_DCACHE_PERF_EN.
module scalar_dcache #(
    parameter int NSETS  = 16,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [WORD_W-1:0] dmemaddr,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [WORD_W-1:0] dmemstore,
    output logic              dhit_in,
    output logic [WORD_W-1:0] dmem_in,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ramwait
`ifdef SCALAR_DCACHE_PERF_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);
    localparam int IDX_W = $clog2(NSETS);
    localparam int TAG_W = WORD_W - 2 - IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, WTHRU} state_t;

    state_t              state;
    state_t              state_n;
    logic [NSETS-1:0]    valid;
    logic [TAG_W-1:0]    tags [NSETS];
    logic [WORD_W-1:0]   data [NSETS];
    logic [WORD_W-3:0]   req_addr;
    logic [WORD_W-1:0]   req_data;
    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [IDX_W-1:0]    ridx;
    logic [TAG_W-1:0]    rtag;
    logic                lookup_hit;
    logic                req_match;
    logic                load_hit;
    logic                fill_done;
    logic                wthru_done;
    logic                unused_lo;

    assign idx        = dmemaddr[2 +: IDX_W];
    assign tag        = dmemaddr[WORD_W-1 -: TAG_W];
    assign ridx       = req_addr[IDX_W-1:0];
    assign rtag       = req_addr[WORD_W-3 -: TAG_W];
    assign lookup_hit = valid[idx] && (tags[idx] == tag);
    assign req_match  = valid[ridx] && (tags[ridx] == rtag);
    assign fill_done  = (state == FILL) && !ramwait;
    assign wthru_done = (state == WTHRU) && !ramwait;
    assign unused_lo  = ^dmemaddr[1:0];

    // State register; reset abandons any transfer at once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    // Next state and all outputs; idle outputs stay zero.
    always_comb begin
        state_n  = state;
        dhit_in  = 1'b0;
        dmem_in  = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        load_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if (dmemWEN) begin
                    state_n = WTHRU;
                end else if (dmemREN) begin
                    if (lookup_hit) begin
                        load_hit = 1'b1;
                        dhit_in  = 1'b1;
                        dmem_in  = data[idx];
                    end else begin
                        state_n = FILL;
                    end
                end
            end
            FILL: begin
                ramREN  = 1'b1;
                ramaddr = {req_addr, 2'b00};
                if (!ramwait) state_n = IDLE;
            end
            WTHRU: begin
                ramWEN   = 1'b1;
                ramaddr  = {req_addr, 2'b00};
                ramstore = req_data;
                if (!ramwait) begin
                    state_n = IDLE;
                    dhit_in = dmemWEN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Capture the request while idle so a transfer is immune to input changes.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            req_addr <= '0;
            req_data <= '0;
        end else if (state == IDLE) begin
            req_addr <= dmemaddr[WORD_W-1:2];
            req_data <= dmemstore;
        end
    end

    // Valid bits: set on fill completion only.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)          valid       <= '0;
        else if (fill_done) valid[ridx] <= 1'b1;
    end

    // Tag/data arrays: fill installs, write-through updates a matching line.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tags[ridx] <= rtag;
            data[ridx] <= ramload;
        end else if (wthru_done && req_match) begin
            data[ridx] <= req_data;
        end
    end

`ifdef SCALAR_DCACHE_PERF_EN
    // Saturating hit/miss counters for load traffic.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (load_hit && hit_cnt != '1)
                hit_cnt <= hit_cnt + 32'd1;
            if (state == IDLE && state_n == FILL && miss_cnt != '1)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule
